// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants and types for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int unsigned UART_CHAR_CYCLES = 8681;
  localparam int unsigned UTXQ_DEPTH       = 16;
  localparam int unsigned UART_DATA_W      = 8;

  typedef enum logic {
    UTXQ_IDLE = 1'b0,
    UTXQ_WAIT = 1'b1
  } utxq_state_e;

  // Write request presented to the uart transmitter.
  typedef struct packed {
    logic                   wr;
    logic [UART_DATA_W-1:0] dat;
  } uart_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; refuses pushes when full and pops when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_W'(1);
      end else if (!do_push && do_pop) begin
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU bytes for the uart and releases them one write pulse per character time.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH       = UTXQ_DEPTH,
  parameter int unsigned CHAR_CYCLES = UART_CHAR_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         stall,
  output logic                         uart_wr,
  output logic [7:0]                   uart_dat,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(CHAR_CYCLES);

  utxq_state_e      state;
  utxq_state_e      state_next;
  logic [CNT_W-1:0] cnt;
  logic             issue;
  logic             push;
  logic             full;
  logic             empty;
  logic [7:0]       head;
  logic [LVL_W-1:0] lvl_next;
  uart_req_t        req;

  assign push     = wr_en & ~full;
  assign stall    = wr_en & full;
  assign uart_wr  = req.wr;
  assign uart_dat = req.dat;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data),
    .pop       (issue),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UTXQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      UTXQ_IDLE: if (!empty) state_next = UTXQ_WAIT;
      UTXQ_WAIT: if (cnt == '0 && empty) state_next = UTXQ_IDLE;
      default:   state_next = UTXQ_IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    case (state)
      UTXQ_IDLE: issue = !empty;
      UTXQ_WAIT: issue = (cnt == '0) && !empty;
      default:   issue = 1'b0;
    endcase
  end

  // Reload with CHAR_CYCLES-1 so the next issue lands exactly CHAR_CYCLES after this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= CNT_W'(CHAR_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    lvl_next = level;
    if (push && !issue) begin
      lvl_next = level + LVL_W'(1);
    end else if (!push && issue) begin
      lvl_next = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req  <= '0;
      busy <= 1'b0;
    end else begin
      req.wr <= issue;
      if (issue) begin
        req.dat <= head;
      end
      busy <= (lvl_next != '0) || (state_next != UTXQ_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with DEPTH=4, CHAR_CYCLES=4.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       stall;
  logic       uart_wr;
  logic [7:0] uart_dat;
  logic       busy;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   pq_cyc[$];
  logic [7:0] pq_dat[$];
  int   sq_cyc[$];
  logic [7:0] sq_dat[$];
  int   lvl_hist[128];
  int   busy_hist[128];
  int   stall_hist[128];
  logic prev_wr = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       e_wr;
    logic [7:0] e_dat;
    logic       e_busy;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t tbl[19];

  uart_tx_scheduler #(
    .DEPTH       (4),
    .CHAR_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .stall    (stall),
    .uart_wr  (uart_wr),
    .uart_dat (uart_dat),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Pulse recorder and per-cycle history, sampled mid-cycle.
  always @(negedge clk) begin
    if (uart_wr) begin
      checks++;
      if (prev_wr) begin
        failures++;
        $display("FAIL uart_wr_back_to_back cyc=%0d got=1 exp=0", cyc);
      end
      pq_cyc.push_back(cyc);
      pq_dat.push_back(uart_dat);
    end
    prev_wr = uart_wr;
    if (cyc < 128) begin
      lvl_hist[cyc]   = int'(level);
      busy_hist[cyc]  = int'(busy);
      stall_hist[cyc] = int'(stall);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    pq_cyc.delete();
    pq_dat.delete();
    sq_cyc.delete();
    sq_dat.delete();
    for (int i = 0; i < 128; i++) begin
      lvl_hist[i] = -1;
      busy_hist[i] = -1;
      stall_hist[i] = -1;
    end
  endtask

  // Drive the scheduled pushes, holding each byte while stall is high.
  task automatic run_sched(input int end_cyc);
    while (cyc <= end_cyc) begin
      if (sq_cyc.size() != 0 && sq_cyc[0] <= cyc) begin
        wr_en = 1'b1;
        wr_data = sq_dat[0];
      end else begin
        wr_en = 1'b0;
        wr_data = 8'h00;
      end
      @(negedge clk);
      if (wr_en && !stall) begin
        void'(sq_cyc.pop_front());
        void'(sq_dat.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    wr_en = 1'b0;
    chk("sched_drained", 32'(sq_cyc.size()), 32'd0);
  endtask

  task automatic check_pulses(input string name, input int n, input int first, input int gap,
                              input logic [7:0] base);
    chk({name, "_count"}, 32'(pq_cyc.size()), 32'(n));
    for (int k = 0; k < n && k < pq_cyc.size(); k++) begin
      chk({name, "_cyc"}, 32'(pq_cyc[k]), 32'(first + k * gap));
      chk({name, "_dat"}, 32'(pq_dat[k]), 32'(base + 8'(k)));
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 8'h31, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[2]  = '{1'b1, 8'h32, 1'b1, 8'h30, 1'b1, 3'd1};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 8'h30, 1'b1, 3'd2};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 3'd3};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 3'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 3'd2};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 3'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 3'd2};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 3'd2};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h32, 1'b1, 3'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b1, 3'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b1, 3'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h32, 1'b1, 3'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 3'd0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 3'd0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 3'd0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 3'd0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 3'd0};

    // Reset state with a store request pending.
    wr_en = 1'b1;
    #1;
    chk("rst_uart_wr", 32'(uart_wr), 32'd0);
    chk("rst_uart_dat", 32'(uart_dat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Burst: cycle-by-cycle vector table from cycle 10.
    do_reset();
    run_sched(9);
    for (int i = 0; i < 19; i++) begin
      wr_en = tbl[i].wr;
      wr_data = tbl[i].din;
      @(negedge clk);
      chk("burst_uart_wr", 32'(uart_wr), 32'(tbl[i].e_wr));
      chk("burst_uart_dat", 32'(uart_dat), 32'(tbl[i].e_dat));
      chk("burst_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("burst_level", 32'(level), 32'(tbl[i].e_lvl));
      chk("burst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    wr_en = 1'b0;
    check_pulses("burst", 4, 12, 4, 8'h30);

    // Single byte latency and busy fall.
    do_reset();
    sq_cyc.push_back(10); sq_dat.push_back(8'h41);
    run_sched(24);
    check_pulses("single", 1, 12, 4, 8'h41);
    chk("single_busy15", 32'(busy_hist[15]), 32'd1);
    chk("single_busy16", 32'(busy_hist[16]), 32'd0);
    chk("single_level16", 32'(lvl_hist[16]), 32'd0);

    // Full FIFO: sixth byte stalls once, then drains in order.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sq_cyc.push_back(10 + k); sq_dat.push_back(8'h50 + 8'(k));
    end
    run_sched(40);
    check_pulses("full", 6, 12, 4, 8'h50);
    chk("full_stall14", 32'(stall_hist[14]), 32'd0);
    chk("full_stall15", 32'(stall_hist[15]), 32'd1);
    chk("full_stall16", 32'(stall_hist[16]), 32'd0);
    chk("full_level15", 32'(lvl_hist[15]), 32'd4);
    chk("full_level17", 32'(lvl_hist[17]), 32'd4);
    chk("full_busy36", 32'(busy_hist[36]), 32'd0);

    // Push on the same cycle as a pop keeps level unchanged.
    do_reset();
    sq_cyc.push_back(11); sq_dat.push_back(8'h60);
    sq_cyc.push_back(13); sq_dat.push_back(8'h61);
    sq_cyc.push_back(16); sq_dat.push_back(8'h62);
    run_sched(30);
    check_pulses("simul", 3, 13, 4, 8'h60);
    chk("simul_level16", 32'(lvl_hist[16]), 32'd1);
    chk("simul_level17", 32'(lvl_hist[17]), 32'd1);

    // Asynchronous reset between edges while in WAIT with bytes queued.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      sq_cyc.push_back(10 + k); sq_dat.push_back(8'h70 + 8'(k));
    end
    run_sched(13);
    chk("mid_level_before", 32'(level), 32'd2);
    wr_en = 1'b1;
    wr_data = 8'h99;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_uart_wr", 32'(uart_wr), 32'd0);
    chk("mid_uart_dat", 32'(uart_dat), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_stall", 32'(stall), 32'd0);
    wr_en = 1'b0;
    #1;
    rst = 1'b0;
    pq_cyc.delete();
    pq_dat.delete();
    sq_cyc.push_back(30); sq_dat.push_back(8'h7a);
    run_sched(40);
    check_pulses("mid_after", 1, 32, 4, 8'h7a);

    // Ten spaced pushes wrap the pointers more than twice.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sq_cyc.push_back(10 + 5 * k); sq_dat.push_back(8'h80 + 8'(k));
    end
    run_sched(65);
    check_pulses("wrap", 10, 12, 5, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Buffers and paces bytes stored by the CPU to the UART address before they reach the `uart` transmitter. It sits between the EX-stage store path of `CPUTop` and the `uart` module. It replaces the direct `uart_we`/`uart_IN_data` wiring with three parts:
- a FIFO;
- a character-time sequencer that issues one single-cycle write pulse per byte, never faster than the line can drain;
- a stall output that holds the pipeline when the FIFO is full.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of two, ≥ 2.
- CHAR_CYCLES, 8681 — minimum clock cycles between successive `uart_wr` pulses (one 10-bit frame); ≥ 2.

Ports:
- clk  in  1  — system clock; all state on rising edge.
- rst  in  1  — reset, asynchronous, active-high.
- wr_en  in  1  — CPU store to UART address this cycle.
- wr_data  in  8  — byte to queue (store data [7:0]).
- stall  out  1  — combinational: `wr_en & full`. The CPU must hold the store and retry while high.
- uart_wr  out  1  — registered one-cycle pulse to `uart.uart_wr_i`.
- uart_dat  out  8  — registered byte to `uart.uart_dat_i`; stable from pulse until next pulse.
- busy  out  1  — registered: FIFO non-empty or sequencer not IDLE.
- level  out  $clog2(DEPTH+1)  — registered FIFO occupancy.

## Operation
- **Reset values:** all outputs 0; FIFO empty; FSM IDLE; counter 0. Reset asserted mid-operation discards all queued and in-flight bytes immediately; no pulse is emitted while `rst` is high.
- **Push:** `wr_en & ~full` writes `wr_data` at the tail. `full` is (level == DEPTH), taken from the registered level.
- **Full:** a push while full is refused and `stall`=1. This holds even if a pop occurs the same cycle; no byte is lost or overwritten.
- **Pop:** occurs only on a cycle where the FSM issues.
- **Simultaneous push and pop when not full:** `level` is unchanged. FIFO order is preserved.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH.
- **FSM states:**
  - **IDLE:** if FIFO non-empty, issue. Issue means: pop the head into `uart_dat`, assert `uart_wr` on the next cycle, load the counter, and go to WAIT.
  - **WAIT:** the counter decrements each cycle. When it reaches terminal, issue again if the FIFO is non-empty, otherwise go to IDLE.
- **Pacing:**
  - With a backlog, consecutive `uart_wr` pulses are exactly CHAR_CYCLES cycles apart.
  - After an idle gap, a pulse is never less than CHAR_CYCLES after the previous one.
- **Arithmetic:** the counter width is $clog2(CHAR_CYCLES). `level` has no overflow, because pushes while full are refused.

## Timing
- **Latency, empty and idle:** `wr_en` accepted in cycle N gives `uart_wr`=1 in cycle N+2, with `uart_dat`=that byte.
- **Latency, backlog:** a byte waits behind each earlier byte for CHAR_CYCLES cycles.
- **`uart_wr` shape:** exactly 1 cycle high per byte. It is never high on two consecutive cycles.
- **`stall` timing:**
  - Combinational, same cycle as `wr_en`.
  - Deasserts the cycle after the first pop from a full FIFO, because `full` is registered.
- **`busy` timing:**
  - Falls CHAR_CYCLES cycles after the last pulse, once the FIFO is empty.
  - Software may poll it through a status read.

## Structure
- The shared `define.v` gains:
  - FSM encodings `UTXQ_IDLE` and `UTXQ_WAIT`;
  - `UART_CHAR_CYCLES`, the default pacing constant.
- `UART_ADDR` stays where it is in `define.v`.
- One sub-module, `sync_fifo`:
  - parameters: width, depth;
  - ports: push, pop, full, empty, level;
  - clock and reset as above.
- The FSM and counter live in `uart_tx_scheduler`.
- In `CPUTop`:
  - `uart_we` drives `wr_en`;
  - `stall` freezes the IF/ID/EX registers;
  - `uart_wr` and `uart_dat` drive `uart`.

## Test plan
All scenarios use DEPTH=4, CHAR_CYCLES=4.
- **Single byte:** reset, then a single push 0x41 at cycle 10 → `uart_wr` high only at cycle 12 with `uart_dat`=0x41; `busy` low from cycle 16; `level` back to 0.
- **Burst:** push 0x30..0x33 on cycles 10–13 → pulses at 12, 16, 20, 24 with data 0x30..0x33 in order; `stall` never high.
- **Full FIFO:** push 6 bytes back-to-back from cycle 10 → `stall` high on the 6th attempt at least. The held byte is accepted once `level` < 4. All 6 bytes come out in order, pulses 4 cycles apart.
- **Simultaneous push and pop:** push one byte at cycle 16, the cycle the queue pops → `level` unchanged at the next edge; no loss or duplication.
- **Reset mid-operation:** 3 bytes queued, async `rst` pulse between edges during WAIT → all outputs 0 immediately. No further `uart_wr` until a new push; a new push after release gives its pulse 2 cycles later.
- **Pointer wrap:** 10 pushes spaced 5 cycles apart → correct order across pointer wrap; every pulse interval ≥ 4.
